// File: rtl/fi_slip_pkg.sv
// Shared constants and index helpers for the fi_slip crossbar scheduler.
package fi_slip_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int N_PORTS  = 8;
    localparam int P_LEVELS = 4;
    localparam int PTR_W    = clog2(N_PORTS);

    function automatic int req_idx(input int i, input int j, input int p);
        return (i * N_PORTS + j) * P_LEVELS + p;
    endfunction

    function automatic int grant_idx(input int i, input int j);
        return i * N_PORTS + j;
    endfunction

endpackage

// File: rtl/rr_prio_arbiter.sv
// Priority-first round-robin arbiter: highest level wins, ties broken by
// scanning from the pointer modulo N. Outputs a one-hot winner and one-hot level.
module rr_prio_arbiter
    import fi_slip_pkg::*;
#(
    parameter int N = N_PORTS,
    parameter int P = P_LEVELS,
    parameter int W = PTR_W
) (
    input  logic [N*P-1:0] i_req,
    input  logic [W-1:0]   i_ptr,
    output logic [N-1:0]   o_winner,
    output logic [P-1:0]   o_level
);

    logic [P-1:0] w_lvl [N];
    logic [P-1:0] w_any;
    logic [P-1:0] w_max;
    logic [N-1:0] w_cand;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lvl
            // Later (higher) set bits overwrite earlier ones, leaving the top one.
            always_comb begin
                w_lvl[gi] = '0;
                for (int p = 0; p < P; p++) begin
                    if (i_req[gi*P+p]) begin
                        w_lvl[gi]    = '0;
                        w_lvl[gi][p] = 1'b1;
                    end
                end
            end
            assign w_cand[gi] = |(w_lvl[gi] & w_max);
        end
    endgenerate

    always_comb begin
        w_any = '0;
        for (int k = 0; k < N; k++) begin
            w_any = w_any | w_lvl[k];
        end
        w_max = '0;
        for (int p = 0; p < P; p++) begin
            if (w_any[p]) begin
                w_max    = '0;
                w_max[p] = 1'b1;
            end
        end
    end

    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        o_winner = '0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(i_ptr) + off) % N;
            if (!found && w_cand[idx]) begin
                o_winner[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign o_level = w_max;

endmodule

// File: rtl/fi_slip.sv
// Flattened-priority single-iteration iSLIP scheduler for an NxN switch.
// Eligibility masking, grant/accept arbiters, pointers, lock mask and output register.
module fi_slip
    import fi_slip_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_PORTS*N_PORTS*P_LEVELS-1:0]  i_priority,
    input  logic [N_PORTS-1:0]                   i_input_idle,
    input  logic [N_PORTS-1:0]                   i_output_idle,
    output logic [N_PORTS*N_PORTS-1:0]           o_acc_grant
);

    localparam int N = N_PORTS;
    localparam int P = P_LEVELS;
    localparam int W = PTR_W;

    logic [N*N-1:0] r_acc_grant;
    logic [W-1:0]   r_gptr [N];
    logic [W-1:0]   r_aptr [N];

    logic [N-1:0]   w_lock_in;
    logic [N-1:0]   w_lock_out;
    logic [N*P-1:0] w_gnt_req [N];
    logic [N-1:0]   w_gnt_win [N];
    logic [P-1:0]   w_gnt_lvl [N];
    logic [N*P-1:0] w_acc_req [N];
    logic [N-1:0]   w_acc_win [N];
    logic [P-1:0]   w_acc_lvl [N];
    logic [N*N-1:0] w_match;

    // Ports matched last cycle are not yet reporting busy, so mask them here.
    always_comb begin
        w_lock_in  = '0;
        w_lock_out = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_lock_in[i]  = w_lock_in[i]  | r_acc_grant[grant_idx(i, j)];
                w_lock_out[j] = w_lock_out[j] | r_acc_grant[grant_idx(i, j)];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            always_comb begin
                w_gnt_req[gi] = '0;
                for (int i = 0; i < N; i++) begin
                    if (i_input_idle[i] && i_output_idle[gi] && !w_lock_in[i] && !w_lock_out[gi]) begin
                        w_gnt_req[gi][i*P +: P] = i_priority[req_idx(i, gi, 0) +: P];
                    end
                end
            end

            rr_prio_arbiter #(.N(N), .P(P), .W(W)) u_grant (
                .i_req    (w_gnt_req[gi]),
                .i_ptr    (r_gptr[gi]),
                .o_winner (w_gnt_win[gi]),
                .o_level  (w_gnt_lvl[gi])
            );

            // A grant carries the output's winning level, which is the pair's own level.
            always_comb begin
                w_acc_req[gi] = '0;
                for (int j = 0; j < N; j++) begin
                    if (w_gnt_win[j][gi]) begin
                        w_acc_req[gi][j*P +: P] = w_gnt_lvl[j];
                    end
                end
            end

            rr_prio_arbiter #(.N(N), .P(P), .W(W)) u_accept (
                .i_req    (w_acc_req[gi]),
                .i_ptr    (r_aptr[gi]),
                .o_winner (w_acc_win[gi]),
                .o_level  (w_acc_lvl[gi])
            );

            assign w_match[gi*N +: N] = w_acc_win[gi] & {N{|w_acc_lvl[gi]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_grant <= '0;
            for (int k = 0; k < N; k++) begin
                r_gptr[k] <= '0;
                r_aptr[k] <= '0;
            end
        end else begin
            r_acc_grant <= w_match;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (w_match[grant_idx(i, j)]) begin
                        r_aptr[i] <= W'((j + 1) % N);
                        r_gptr[j] <= W'((i + 1) % N);
                    end
                end
            end
        end
    end

    assign o_acc_grant = r_acc_grant;

endmodule

// File: tb/tb_fi_slip.sv
// Directed bench for fi_slip: integer-level iSLIP reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_fi_slip;

    localparam int N = 8;
    localparam int P = 4;

    logic            clk;
    logic            reset;
    logic [N*N*P-1:0] prio;
    logic [N-1:0]    in_idle;
    logic [N-1:0]    out_idle;
    logic [N*N-1:0]  o_acc_grant;

    int tests = 0;
    int fails = 0;

    logic [N*N-1:0] exp_grant = '0;
    int g_m [N] = '{default: 0};
    int a_m [N] = '{default: 0};

    fi_slip dut (
        .clk           (clk),
        .reset         (reset),
        .i_priority    (prio),
        .i_input_idle  (in_idle),
        .i_output_idle (out_idle),
        .o_acc_grant   (o_acc_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int level_of(int i, int j);
        for (int p = P - 1; p >= 0; p--) begin
            if (prio[(i*N+j)*P+p]) return p;
        end
        return -1;
    endfunction

    function automatic bit eligible(int i, int j);
        bit row_used, col_used;
        row_used = 1'b0;
        col_used = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (exp_grant[i*N+k]) row_used = 1'b1;
            if (exp_grant[k*N+j]) col_used = 1'b1;
        end
        return in_idle[i] && out_idle[j] && !row_used && !col_used && (level_of(i, j) >= 0);
    endfunction

    // Reference model: request/grant/accept on integer levels.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_grant <= '0;
            for (int k = 0; k < N; k++) begin
                g_m[k] <= 0;
                a_m[k] <= 0;
            end
        end else begin : model
            int gnt [N];
            int best, sel, ii, jj;
            logic [N*N-1:0] nxt;
            nxt = '0;
            for (int j = 0; j < N; j++) begin
                best = -1;
                for (int i = 0; i < N; i++)
                    if (eligible(i, j) && level_of(i, j) > best) best = level_of(i, j);
                gnt[j] = -1;
                for (int k = 0; k < N; k++) begin
                    ii = (g_m[j] + k) % N;
                    if (best >= 0 && gnt[j] < 0 && eligible(ii, j) && level_of(ii, j) == best) gnt[j] = ii;
                end
            end
            for (int i = 0; i < N; i++) begin
                best = -1;
                for (int j = 0; j < N; j++)
                    if (gnt[j] == i && level_of(i, j) > best) best = level_of(i, j);
                sel = -1;
                for (int k = 0; k < N; k++) begin
                    jj = (a_m[i] + k) % N;
                    if (best >= 0 && sel < 0 && gnt[jj] == i && level_of(i, jj) == best) sel = jj;
                end
                if (sel >= 0) begin
                    nxt[i*N+sel] = 1'b1;
                    a_m[i]   <= (sel + 1) % N;
                    g_m[sel] <= (i + 1) % N;
                end
            end
            exp_grant <= nxt;
        end
    end

    always @(negedge clk) begin
        tests++;
        if (o_acc_grant !== exp_grant) begin
            fails++;
            $display("FAIL model_cmp t=%0t got=%h want=%h", $time, o_acc_grant, exp_grant);
        end
    end

    task automatic chk(input string name, input logic [N*N-1:0] got, input logic [N*N-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("[TB] %s ok: %h", name, got);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else begin
            $display("[TB] %s ok: %0d", name, got);
        end
    endtask

    task automatic set_req(input int i, input int j, input int p);
        prio[(i*N+j)*P+p] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        prio  = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [N*N-1:0] rr_exp [8];
    logic [N*N-1:0] one;

    initial begin
        one      = 64'h1;
        reset    = 1'b1;
        prio     = '0;
        in_idle  = '1;
        out_idle = '1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", o_acc_grant, '0);

        // Single request (2,5,p0)
        reset = 1'b1;
        set_req(2, 5, 0);
        @(negedge clk);
        chk("single_match", o_acc_grant, one << 21);
        chk_int("single_g5", g_m[5], 3);
        chk_int("single_a2", a_m[2], 6);
        prio = '0;
        @(negedge clk);
        chk("single_pulse", o_acc_grant, '0);

        // Round-robin on output 4, alternating with lock cycles
        do_reset();
        set_req(0, 4, 1);
        set_req(1, 4, 1);
        set_req(2, 4, 1);
        rr_exp = '{one << 4, '0, one << 12, '0, one << 20, '0, one << 4, '0};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr_cycle%0d", k), o_acc_grant, rr_exp[k]);
        end

        // Priority override on output 3
        do_reset();
        set_req(0, 3, 0);
        set_req(6, 3, 3);
        @(negedge clk);
        chk("prio_override", o_acc_grant, one << 51);

        // Busy output 4 masks its column until it returns to idle
        do_reset();
        set_req(0, 4, 0);
        set_req(1, 4, 0);
        out_idle[4] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("busy_col%0d", k), o_acc_grant, '0);
        end
        out_idle = '1;
        @(negedge clk);
        chk("busy_release", o_acc_grant, one << 4);

        // Full load: a rotation match sets g[j]=j, then all pairs give identity
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, (i + 1) % N, 2);
        @(negedge clk);
        chk("perm_match", o_acc_grant, 64'h0180402010080402);
        prio = '0;
        @(negedge clk);
        chk("perm_lock", o_acc_grant, '0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) set_req(i, j, 2);
        @(negedge clk);
        chk("full_identity", o_acc_grant, 64'h8040201008040201);
        @(negedge clk);
        chk("full_lock", o_acc_grant, '0);
        repeat (6) @(negedge clk);

        // Asynchronous reset while matches are issuing
        #2 reset = 1'b0;
        #1 chk("mid_reset", o_acc_grant, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset", o_acc_grant, one);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
